// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: FSM states, funct3 access codes and
// write-back result-source selectors.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Access size from funct3[1:0]: 0 byte, 1 half, 2 word (1x codes are word).
    function automatic logic [1:0] access_size(input logic [1:0] f3_lo);
        logic [1:0] size;
        case (f3_lo)
            2'b00:   size = 2'd0;
            2'b01:   size = 2'd1;
            default: size = 2'd2;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_cycle_load_ext.sv
// Load data alignment: selects the addressed byte/half of the returned word
// and sign- or zero-extends it to 32 bits.
module load_ext
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension; unknown funct3 codes fall back to a full word.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (funct3_i)
            LB:      data_o = {{24{byte_s[7]}}, byte_s};
            LBU:     data_o = {24'h000000, byte_s};
            LH:      data_o = {{16{half_s[15]}}, half_s};
            LHU:     data_o = {16'h0000, half_s};
            LW:      data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_cycle.sv
// Pipeline memory stage: issues loads/stores on the data bus, stalls while a
// transaction is outstanding and registers results into MEM/WB.
module mem_cycle
    import mem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        insn_vldM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        misalignW,
    output logic        insn_vldW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W
);

    state_e      state_q, state_d;
    logic        mem_op_s, misalign_s, req_s, stall_s, mis_s, rsp_s;
    logic [1:0]  off_s, size_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, ext_s;

    logic        insn_vld_q, reg_write_q, misalign_q;
    logic [1:0]  result_src_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_result_q, read_data_q, pc_plus4_q;

    assign off_s    = ALU_ResultM[1:0];
    assign size_s   = access_size(funct3M[1:0]);
    assign mem_op_s = insn_vldM & (MemWriteM | (ResultSrcM == RES_LOAD));

    // Alignment check against the access size.
    always_comb begin
        case (size_s)
            2'd1:    misalign_s = off_s[0];
            2'd2:    misalign_s = (off_s != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        case (funct3M)
            SB: begin
                be_s    = 4'b0001 << off_s;
                wdata_s = {4{WriteDataM[7:0]}};
            end
            SH: begin
                be_s    = 4'b0011 << off_s;
                wdata_s = {2{WriteDataM[15:0]}};
            end
            SW: begin
                be_s    = 4'b1111;
                wdata_s = WriteDataM;
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = WriteDataM;
            end
        endcase
    end

    // Next-state and bus/stall control.
    always_comb begin
        state_d = state_q;
        req_s   = 1'b0;
        stall_s = 1'b0;
        mis_s   = 1'b0;
        rsp_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_s && misalign_s) begin
                    mis_s = 1'b1;
                end else if (mem_op_s) begin
                    req_s = 1'b1;
                    if (!dmem_ready) begin
                        stall_s = 1'b1;
                    end else if (MemWriteM) begin
                        stall_s = 1'b0;
                    end else begin
                        stall_s = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    rsp_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB pipeline register; stalled cycles become bubbles with fields held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            insn_vld_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            misalign_q   <= 1'b0;
            result_src_q <= 2'b00;
            rd_q         <= 5'd0;
            alu_result_q <= 32'h0000_0000;
            read_data_q  <= 32'h0000_0000;
            pc_plus4_q   <= 32'h0000_0000;
        end else if (stall_s) begin
            insn_vld_q  <= 1'b0;
            reg_write_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            insn_vld_q   <= insn_vldM & ~mis_s;
            reg_write_q  <= insn_vldM & RegWriteM & ~mis_s;
            misalign_q   <= mis_s;
            result_src_q <= ResultSrcM;
            rd_q         <= RdM;
            alu_result_q <= ALU_ResultM;
            pc_plus4_q   <= PCPlus4M;
            if (rsp_s) begin
                read_data_q <= ext_s;
            end
        end
    end

    load_ext u_load_ext (
        .funct3_i  (funct3M),
        .addr_lo_i (off_s),
        .rdata_i   (dmem_rdata),
        .data_o    (ext_s)
    );

    // Request and stall are suppressed while reset is held.
    assign dmem_req    = req_s & i_rst_n;
    assign stallM      = stall_s & i_rst_n;
    assign dmem_we     = MemWriteM;
    assign dmem_addr   = {ALU_ResultM[31:2], 2'b00};
    assign dmem_be     = be_s;
    assign dmem_wdata  = wdata_s;

    assign insn_vldW   = insn_vld_q;
    assign RegWriteW   = reg_write_q;
    assign misalignW   = misalign_q;
    assign ResultSrcW  = result_src_q;
    assign RdW         = rd_q;
    assign ALU_ResultW = alu_result_q;
    assign ReadDataW   = read_data_q;
    assign PCPlus4W    = pc_plus4_q;

endmodule

// File: tb/tb_mem_cycle.sv
// Scoreboard bench for mem_cycle: directed M-stage vectors push expected W
// results; a negedge monitor pops and compares whenever W presents a result.
module tb_mem_cycle;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        insn_vldM, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stallM, misalignW, insn_vldW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

    always #5 i_clk = ~i_clk;

    mem_cycle dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .insn_vldM(insn_vldM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .misalignW(misalignW), .insn_vldW(insn_vldW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
    );

    typedef struct {
        logic        vld;
        logic        mis;
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pc4_of(input logic [4:0] rd);
        return 32'h0000_1000 + {27'd0, rd};
    endfunction

    task automatic set_m(input logic vld, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd);
        insn_vldM = vld; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
        funct3M = f3; ALU_ResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4_of(rd);
    endtask

    task automatic idle();
        set_m(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic push(input logic vld, input logic mis, input logic rw, input logic [1:0] rs,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic chk_rd);
        exp_t e;
        e.vld = vld; e.mis = mis; e.rw = rw; e.rs = rs; e.rd = rd;
        e.alu = alu; e.rdat = rdat; e.chk_rd = chk_rd;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Retire cycle: idle M, check that the op reached W exactly one edge later.
    task automatic finish_op(input string name, input logic exp_vld);
        next_cycle();
        idle();
        dmem_rvalid = 1'b0;
        @(negedge i_clk);
        chk({name, "_w_lat"}, 32'(insn_vldW), 32'(exp_vld));
        next_cycle();
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd);
        set_m(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, res, 32'h0, rd);
        push(1'b1, 1'b0, 1'b1, 2'b00, rd, res, 32'h0, 1'b0);
        @(negedge i_clk);
        chk("alu_stall", 32'(stallM), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        finish_op("alu", 1'b1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] wdata);
        set_m(1'b1, 1'b0, 2'b00, 1'b1, f3, addr, wd, 5'd0);
        dmem_ready = 1'b1;
        push(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, addr, 32'h0, 1'b0);
        @(negedge i_clk);
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("st_be", 32'(dmem_be), 32'(be));
        chk("st_wdata", dmem_wdata, wdata);
        chk("st_stall", 32'(stallM), 32'd0);
        finish_op("st", 1'b1);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input int wait_rdy, input int lat, input logic [4:0] rd,
                           input logic [31:0] exp);
        set_m(1'b1, 1'b1, 2'b01, 1'b0, f3, addr, 32'h0, rd);
        push(1'b1, 1'b0, 1'b1, 2'b01, rd, addr, exp, 1'b1);
        dmem_ready = 1'b0;
        for (int i = 0; i < wait_rdy; i++) begin
            @(negedge i_clk);
            chk("ld_wait_req", 32'(dmem_req), 32'd1);
            chk("ld_wait_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("ld_wait_we", 32'(dmem_we), 32'd0);
            chk("ld_wait_stall", 32'(stallM), 32'd1);
            chk("ld_wait_bubble", 32'(insn_vldW), 32'd0);
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge i_clk);
        chk("ld_acc_req", 32'(dmem_req), 32'd1);
        chk("ld_acc_stall", 32'(stallM), 32'd1);
        next_cycle();
        dmem_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge i_clk);
            chk("ld_resp_req", 32'(dmem_req), 32'd0);
            chk("ld_resp_stall", 32'(stallM), 32'd1);
            chk("ld_resp_bubble", 32'(insn_vldW), 32'd0);
            next_cycle();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge i_clk);
        chk("ld_rv_stall", 32'(stallM), 32'd0);
        finish_op("ld", 1'b1);
    endtask

    task automatic do_mis(input logic [2:0] f3, input logic [31:0] addr, input logic mw);
        set_m(1'b1, 1'b1, mw ? 2'b00 : 2'b01, mw, f3, addr, 32'h0, 5'd3);
        dmem_ready = 1'b1;
        push(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stallM), 32'd0);
        finish_op("mis", 1'b0);
        chk("mis_one_cycle", 32'(misalignW), 32'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge i_clk) begin
        if (insn_vldW || misalignW) begin
            if (exp_q.size() == 0) begin
                chk("w_unexpected", 32'(insn_vldW), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("w_vld", 32'(insn_vldW), 32'(mon_e.vld));
                chk("w_mis", 32'(misalignW), 32'(mon_e.mis));
                chk("w_regwrite", 32'(RegWriteW), 32'(mon_e.rw));
                if (mon_e.vld) begin
                    chk("w_rd", 32'(RdW), 32'(mon_e.rd));
                    chk("w_rsrc", 32'(ResultSrcW), 32'(mon_e.rs));
                    chk("w_alu", ALU_ResultW, mon_e.alu);
                    chk("w_pc4", PCPlus4W, pc4_of(mon_e.rd));
                    if (mon_e.chk_rd) begin
                        chk("w_rdata", ReadDataW, mon_e.rdat);
                    end
                end
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        set_m(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd1);
        @(negedge i_clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        chk("rst_vldW", 32'(insn_vldW), 32'd0);
        chk("rst_misW", 32'(misalignW), 32'd0);
        chk("rst_aluW", ALU_ResultW, 32'd0);
        next_cycle();
        idle();
        i_rst_n = 1'b1;
        next_cycle();

        do_alu(32'h0000_1234, 5'd5);
        do_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        do_store(3'b001, 32'h0000_0102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        do_load(3'b000, 32'h0000_0102, 32'h0080_0000, 0, 3, 5'd7,  32'hFFFF_FF80);
        do_load(3'b100, 32'h0000_0102, 32'h0080_0000, 0, 3, 5'd8,  32'h0000_0080);
        do_load(3'b001, 32'h0000_0102, 32'h8001_1234, 0, 1, 5'd10, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_0100, 32'h8001_F234, 0, 2, 5'd11, 32'h0000_F234);
        do_load(3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 1, 5'd12, 32'hDEAD_BEEF);
        do_load(3'b011, 32'h0000_0108, 32'h8765_4321, 0, 1, 5'd13, 32'h8765_4321);
        do_load(3'b000, 32'h0000_0101, 32'h0000_7F00, 0, 1, 5'd14, 32'h0000_007F);
        do_mis(3'b001, 32'h0000_0101, 1'b0);
        do_mis(3'b010, 32'h0000_0106, 1'b1);

        // Reset while waiting for a load response; the late rvalid must be dropped.
        set_m(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
        dmem_ready = 1'b1;
        @(negedge i_clk);
        chk("rr_acc_stall", 32'(stallM), 32'd1);
        next_cycle();
        idle();
        dmem_ready = 1'b0;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("rr_rst_stall", 32'(stallM), 32'd0);
        chk("rr_rst_vldW", 32'(insn_vldW), 32'd0);
        next_cycle();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rr_idle_stall", 32'(stallM), 32'd0);
        next_cycle();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        @(negedge i_clk);
        chk("rr_late_stall", 32'(stallM), 32'd0);
        next_cycle();
        dmem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("rr_late_vldW", 32'(insn_vldW), 32'd0);
        chk("rr_late_rwW", 32'(RegWriteW), 32'd0);
        chk("rr_late_rdataW", ReadDataW, 32'd0);
        next_cycle();
        do_alu(32'h0000_0077, 5'd6);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_cycle.md
# mem_cycle

Memory stage of the five-stage pipeline, directly upstream of the write-back stage. Takes execute-stage results for the instruction in M, performs loads and stores over a request/response data-memory bus with byte enables, aligns and sign/zero-extends load data, and registers everything into the MEM/WB pipeline register consumed by write-back. Stalls the front of the pipeline while a memory transaction is outstanding.

## Interface
- No parameters; XLEN fixed at 32.
- i_clk  in  1  pipeline clock
- i_rst_n  in  1  asynchronous active-low reset
- insn_vldM  in  1  instruction in M is valid
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4
- MemWriteM  in  1  instruction is a store
- funct3M  in  3  access size/sign
- ALU_ResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data, rs2
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- dmem_req  out  1  request valid
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  32  word-aligned address, {ALU_ResultM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- stallM  out  1  hold F/D/E/M registers
- misalignW  out  1  registered misaligned-access flag
- insn_vldW, RegWriteW  out  1 each  to write-back
- ResultSrcW  out  2;  RdW  out  5;  ALU_ResultW, ReadDataW, PCPlus4W  out  32 each

## Operation
- Memory op: insn_vldM & (MemWriteM | ResultSrcM==01). Non-memory ops pass straight to MEM/WB, never stall.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. No dmem_req; W receives insn_vldW=0, RegWriteW=0, misalignW=1 for one cycle.
- Store enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. wdata: byte replicated x4, half replicated x2.
- Load extend: LB/LBU select byte addr[1:0], LH/LHU select half addr[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend. Illegal funct3 (011,11x) treated as LW.
- FSM, states IDLE, RESP:
  - IDLE: memory op → dmem_req=1 combinationally. Not ready → stallM=1, stay. Ready & store → no stall, store retires to W this edge. Ready & load → stallM=1, go RESP.
  - RESP: dmem_req=0, stallM=1 until dmem_rvalid; on rvalid capture extended data into ReadDataW with load's control, stallM=0 that cycle, go IDLE.
- dmem_rvalid in IDLE is ignored.
- Any cycle with stallM=1 loads a bubble into MEM/WB (insn_vldW=0, RegWriteW=0, other fields don't-care but held).

## Timing
- Reset: state IDLE; all W outputs, misalignW zero; dmem_req=0, stallM=0 while asserted.
- ALU/PC+4 ops and accepted stores: 1 cycle M→W.
- Load: minimum 2 cycles (accept cycle, rvalid no earlier than next cycle); stallM high from accept cycle through the cycle before rvalid.
- Request fields stable while dmem_req held and not ready.
- Reset mid-transaction: abandon; late rvalid discarded in IDLE.

## Structure
- mem_pkg: state enum {IDLE,RESP}; funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW; ResultSrc encodings RES_ALU/RES_LOAD/RES_PC4.
- Sub-module load_ext: combinational lane select and extension (funct3, addr[1:0], rdata → 32-bit result). Store lane logic, FSM and MEM/WB register stay in mem_cycle.

## Test plan
- ADD, ALU_ResultM=0x1234, RdM=5, ResultSrcM=00 → next cycle ALU_ResultW=0x1234, RdW=5, RegWriteW=1, stallM never high.
- SB addr 0x103, WriteDataM=0xAB, ready=1 → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, no stall.
- LB addr 0x102, rdata=0x00800000 with rvalid 3 cycles after accept → stallM high 3 cycles, ReadDataW=0xFFFFFF80; LBU same → 0x00000080.
- LW with dmem_ready low 2 cycles → req held, fields stable, stallM high, bubbles (insn_vldW=0) into W.
- LH addr 0x101 → no request, misalignW=1, RegWriteW=0 for one cycle.
- Reset asserted in RESP, rvalid arrives after release → ignored, W outputs stay zero, state IDLE.
